// File: rtl/display_control.sv
// Four-digit multiplexed seven-segment driver for a 12-bit binary value.
// A double-dabble FSM converts on change; the refresh path reads only the committed bcd.
module display_control #(
    parameter int unsigned REFRESH_DIV = 27000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] acumulador,
    output logic [3:0]  anodo,
    output logic [6:0]  segmentos,
    output logic [15:0] bcd,
    output logic        busy
);

    localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_t;

    state_t        r_state;
    logic [11:0]   r_last;
    logic [11:0]   r_bin;
    logic [15:0]   r_scratch;
    logic [15:0]   r_bcd;
    logic [3:0]    r_step;
    logic          r_busy;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_digit;
    logic [3:0]    r_anodo;
    logic [6:0]    r_seg;

    logic [15:0]   w_adj;
    logic          w_wrap;
    logic [1:0]    w_digit_next;
    logic [3:0]    w_nibble;
    logic          w_blank;
    logic [6:0]    w_seg;

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 4; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_last    <= '0;
            r_bin     <= '0;
            r_scratch <= '0;
            r_bcd     <= '0;
            r_step    <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (acumulador != r_last) begin
                        r_state <= StLoad;
                        r_busy  <= 1'b1;
                    end
                end
                StLoad: begin
                    r_bin     <= acumulador;
                    r_last    <= acumulador;
                    r_scratch <= '0;
                    r_step    <= '0;
                    r_state   <= StShift;
                end
                StShift: begin
                    {r_scratch, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
                    r_step             <= r_step + 4'd1;
                    if (r_step == 4'd11) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_bcd   <= r_scratch;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_wrap       = (r_presc == PRESC_LAST);
    assign w_digit_next = w_wrap ? r_digit + 2'd1 : r_digit;

    // Outputs are registered from the next index so anodo tracks the index exactly.
    always_comb begin
        w_nibble = r_bcd[4*w_digit_next +: 4];
        w_blank  = 1'b0;
        case (w_digit_next)
            2'd3:    w_blank = (r_bcd[15:12] == 4'd0);
            2'd2:    w_blank = (r_bcd[15:8] == 8'd0);
            2'd1:    w_blank = (r_bcd[15:4] == 12'd0);
            default: w_blank = 1'b0;
        endcase
        case (w_nibble)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = 7'b1111111;
        endcase
        if (w_blank) begin
            w_seg = 7'b1111111;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_digit <= 2'd0;
            r_anodo <= 4'b1110;
            r_seg   <= 7'b1000000;
        end else begin
            r_presc <= w_wrap ? '0 : r_presc + 1'b1;
            r_digit <= w_digit_next;
            r_anodo <= ~(4'b0001 << w_digit_next);
            r_seg   <= w_seg;
        end
    end

    assign anodo     = r_anodo;
    assign segmentos = r_seg;
    assign bcd       = r_bcd;
    assign busy      = r_busy;

endmodule

// File: tb/tb_display_control.sv
// Directed bench for display_control with a short refresh divider.
module tb_display_control;

    logic        clk;
    logic        rst;
    logic [11:0] acumulador;
    logic [3:0]  anodo;
    logic [6:0]  segmentos;
    logic [15:0] bcd;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    display_control #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .acumulador (acumulador),
        .anodo      (anodo),
        .segmentos  (segmentos),
        .bcd        (bcd),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a new value and measure busy-high cycles and first bcd change (cycle 1 = E0).
    task automatic convert(input logic [11:0] v, output int busy_cnt, output int lat);
        logic [15:0] prev;
        prev       = bcd;
        busy_cnt   = 0;
        lat        = -1;
        acumulador = v;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (lat < 0 && bcd !== prev) lat = cyc;
        end
    endtask

    // Wait (bounded) for the given digit to be enabled and return its segments.
    task automatic seg_for(input int idx, output logic [6:0] s);
        logic [3:0] pat;
        logic       found;
        pat   = ~(4'b0001 << idx);
        found = 1'b0;
        s     = 7'bxxxxxxx;
        for (int i = 0; i < 20 && !found; i++) begin
            if (anodo === pat) begin
                s     = segmentos;
                found = 1'b1;
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        acumulador = 12'd0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd got %h want 0000", bcd); end
        n_checks++;
        if (anodo !== 4'b1110) begin n_fail++; $display("FAIL reset_anodo got %b want 1110", anodo); end
        n_checks++;
        if (segmentos !== 7'b1000000) begin
            n_fail++; $display("FAIL reset_seg got %b want 1000000", segmentos);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_refresh_zero();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int         busy_cnt;
        busy_cnt = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            exp_an  = ~(4'b0001 << ((cyc / 4) % 4));
            exp_seg = (((cyc / 4) % 4) == 0) ? 7'b1000000 : 7'b1111111;
            if (busy === 1'b1) busy_cnt++;
            n_checks++;
            if (anodo !== exp_an) begin
                n_fail++; $display("FAIL refresh_anodo cyc %0d got %b want %b", cyc, anodo, exp_an);
            end
            n_checks++;
            if (segmentos !== exp_seg) begin
                n_fail++;
                $display("FAIL refresh_seg cyc %0d got %b want %b", cyc, segmentos, exp_seg);
            end
        end
        n_checks++;
        if (busy_cnt != 0) begin n_fail++; $display("FAIL idle_busy got %0d want 0", busy_cnt); end
        n_checks++;
        if (bcd !== 16'h0000) begin n_fail++; $display("FAIL idle_bcd got %h want 0000", bcd); end
    endtask

    task automatic test_1234();
        int         bc, lat;
        logic [6:0] s;
        convert(12'd1234, bc, lat);
        n_checks++;
        if (bc != 14) begin n_fail++; $display("FAIL c1234_busy got %0d want 14", bc); end
        n_checks++;
        if (lat != 15) begin n_fail++; $display("FAIL c1234_latency got %0d want 15", lat); end
        n_checks++;
        if (bcd !== 16'h1234) begin n_fail++; $display("FAIL c1234_bcd got %h want 1234", bcd); end
        seg_for(0, s);
        n_checks++;
        if (s !== 7'b0011001) begin n_fail++; $display("FAIL c1234_d0 got %b want 0011001", s); end
        seg_for(1, s);
        n_checks++;
        if (s !== 7'b0110000) begin n_fail++; $display("FAIL c1234_d1 got %b want 0110000", s); end
        seg_for(2, s);
        n_checks++;
        if (s !== 7'b0100100) begin n_fail++; $display("FAIL c1234_d2 got %b want 0100100", s); end
        seg_for(3, s);
        n_checks++;
        if (s !== 7'b1111001) begin n_fail++; $display("FAIL c1234_d3 got %b want 1111001", s); end
    endtask

    task automatic test_4095();
        int         bc, lat;
        logic [6:0] s;
        convert(12'd4095, bc, lat);
        n_checks++;
        if (lat != 15) begin n_fail++; $display("FAIL c4095_latency got %0d want 15", lat); end
        n_checks++;
        if (bcd !== 16'h4095) begin n_fail++; $display("FAIL c4095_bcd got %h want 4095", bcd); end
        seg_for(2, s);
        n_checks++;
        if (s !== 7'b1000000) begin n_fail++; $display("FAIL c4095_d2 got %b want 1000000", s); end
        seg_for(3, s);
        n_checks++;
        if (s !== 7'b0011001) begin n_fail++; $display("FAIL c4095_d3 got %b want 0011001", s); end
        seg_for(0, s);
        n_checks++;
        if (s !== 7'b0010010) begin n_fail++; $display("FAIL c4095_d0 got %b want 0010010", s); end
    endtask

    task automatic test_7();
        int         bc, lat;
        logic [6:0] s;
        convert(12'd7, bc, lat);
        n_checks++;
        if (bcd !== 16'h0007) begin n_fail++; $display("FAIL c7_bcd got %h want 0007", bcd); end
        for (int d = 1; d <= 3; d++) begin
            seg_for(d, s);
            n_checks++;
            if (s !== 7'b1111111) begin
                n_fail++; $display("FAIL c7_blank_d%0d got %b want 1111111", d, s);
            end
        end
        seg_for(0, s);
        n_checks++;
        if (s !== 7'b1111000) begin n_fail++; $display("FAIL c7_d0 got %b want 1111000", s); end
    endtask

    task automatic test_change_midconv();
        logic [15:0] prev;
        logic [15:0] vals [4];
        int          cycs [4];
        int          nchg;
        nchg       = 0;
        prev       = bcd;
        acumulador = 12'd100;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            if (cyc == 7) acumulador = 12'd205;
            @(posedge clk);
            @(negedge clk);
            if (bcd !== prev) begin
                if (nchg < 4) begin
                    vals[nchg] = bcd;
                    cycs[nchg] = cyc;
                end
                nchg++;
                prev = bcd;
            end
        end
        n_checks++;
        if (nchg != 2) begin n_fail++; $display("FAIL change_count got %0d want 2", nchg); end
        if (nchg >= 1) begin
            n_checks++;
            if (vals[0] !== 16'h0100 || cycs[0] != 15) begin
                n_fail++;
                $display("FAIL change_first got %h@%0d want 0100@15", vals[0], cycs[0]);
            end
        end
        if (nchg >= 2) begin
            n_checks++;
            if (vals[1] !== 16'h0205 || cycs[1] != 30) begin
                n_fail++;
                $display("FAIL change_second got %h@%0d want 0205@30", vals[1], cycs[1]);
            end
        end
    endtask

    task automatic test_reset_midconv();
        int bc, lat;
        acumulador = 12'd999;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy got %b want 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_checks++;
        if (bcd !== 16'h0000) begin n_fail++; $display("FAIL midrst_bcd got %h want 0000", bcd); end
        n_checks++;
        if (anodo !== 4'b1110) begin n_fail++; $display("FAIL midrst_anodo got %b want 1110", anodo); end
        n_checks++;
        if (segmentos !== 7'b1000000) begin
            n_fail++; $display("FAIL midrst_seg got %b want 1000000", segmentos);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        convert(12'd999, bc, lat);
        n_checks++;
        if (bc != 14) begin n_fail++; $display("FAIL midrst_busy_cnt got %0d want 14", bc); end
        n_checks++;
        if (lat != 15) begin n_fail++; $display("FAIL midrst_latency got %0d want 15", lat); end
        n_checks++;
        if (bcd !== 16'h0999) begin n_fail++; $display("FAIL midrst_bcd_after got %h want 0999", bcd); end
    endtask

    initial begin
        test_reset();
        test_refresh_zero();
        test_1234();
        test_4095();
        test_7();
        test_change_midconv();
        test_reset_midconv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
